// File: rtl/sd_cmd_serializer.sv
// SD CMD-line serializer: takes raw command bytes through a one-byte holding
// buffer, shifts them out MSB-first, then appends CRC7 and the end bit.
module sd_cmd_serializer #(
  parameter int   MAX_BYTES  = 6,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sd_enable,
  input  logic       sending,
  input  logic       byte_valid,
  input  logic [7:0] data,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       sd_cmd,
  output logic       sd_cmd_oe,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_CRC    = 3'd2,
    S_ENDBIT = 3'd3,
    S_DONE   = 3'd4,
    S_ABORT  = 3'd5
  } state_e;

  localparam int BCW = $clog2(MAX_BYTES + 1);

  // CRC7, polynomial x^7 + x^3 + 1, fed one bit at a time MSB-first.
  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_e         state_q;
  logic [7:0]     hold_q;
  logic           hold_last_q;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     shift_q;
  logic           last_q;
  logic [6:0]     crc_q;
  logic [2:0]     bit_cnt_q;
  logic [BCW-1:0] byte_cnt_q;
  logic           sd_cmd_q, oe_q, frame_done_q, underrun_q;

  logic accept, byte_end, end_frame, drain, hold_clear;

  // Handshake: a byte is taken on any cycle where byte_valid & sending & byte_ready.
  assign accept     = byte_valid && sending && !hold_full_q;
  assign byte_end   = (state_q == S_SHIFT) && sd_enable && (bit_cnt_q == 3'd7);
  assign end_frame  = last_q || (byte_cnt_q == BCW'(MAX_BYTES - 1));
  assign drain      = hold_full_q && (((state_q == S_IDLE) && sd_enable) ||
                                      (byte_end && !end_frame));
  assign hold_clear = (state_q == S_ABORT);

  always_comb begin
    hold_full_d = hold_full_q;
    if (hold_clear)  hold_full_d = 1'b0;
    else if (accept) hold_full_d = 1'b1;
    else if (drain)  hold_full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_full_q <= 1'b0;
      hold_q      <= 8'h00;
      hold_last_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      if (hold_clear) begin
        hold_q      <= 8'h00;
        hold_last_q <= 1'b0;
      end else if (accept) begin
        hold_q      <= data;
        hold_last_q <= byte_last;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      shift_q      <= 8'h00;
      last_q       <= 1'b0;
      crc_q        <= 7'h00;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= '0;
      sd_cmd_q     <= IDLE_LEVEL;
      oe_q         <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sd_cmd_q <= IDLE_LEVEL;
          oe_q     <= 1'b0;
          // The starting strobe already puts the MSB of the first byte on the line.
          if (sd_enable && hold_full_q) begin
            sd_cmd_q   <= hold_q[7];
            oe_q       <= 1'b1;
            shift_q    <= {hold_q[6:0], 1'b0};
            last_q     <= hold_last_q;
            crc_q      <= crc7_next(7'h00, hold_q[7]);
            bit_cnt_q  <= 3'd1;
            byte_cnt_q <= BCW'(1);
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (sd_enable) begin
            sd_cmd_q  <= shift_q[7];
            crc_q     <= crc7_next(crc_q, shift_q[7]);
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (end_frame) begin
                state_q <= S_CRC;
              end else if (hold_full_q) begin
                shift_q    <= hold_q;
                last_q     <= hold_last_q;
                byte_cnt_q <= byte_cnt_q + BCW'(1);
              end else begin
                state_q <= S_ABORT;
              end
            end
          end
        end
        S_CRC: begin
          // bit_cnt_q wrapped to 0 on the way in and now indexes the CRC bits.
          if (sd_enable) begin
            sd_cmd_q  <= crc_q[3'd6 - bit_cnt_q];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd6) state_q <= S_ENDBIT;
          end
        end
        S_ENDBIT: begin
          if (sd_enable) begin
            sd_cmd_q <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          frame_done_q <= 1'b1;
          oe_q         <= 1'b0;
          sd_cmd_q     <= IDLE_LEVEL;
          state_q      <= S_IDLE;
        end
        S_ABORT: begin
          underrun_q <= 1'b1;
          oe_q       <= 1'b0;
          sd_cmd_q   <= IDLE_LEVEL;
          state_q    <= S_IDLE;
        end
        default: begin
          oe_q     <= 1'b0;
          sd_cmd_q <= IDLE_LEVEL;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready = !hold_full_q;
  assign sd_cmd     = sd_cmd_q;
  assign sd_cmd_oe  = oe_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Directed bench for sd_cmd_serializer: full CMD0/CMD8 frames, slow strobe,
// underrun stall, forced end-of-frame and asynchronous reset mid-frame.
module tb_sd_cmd_serializer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sd_enable, sending, byte_valid, byte_last;
  logic [7:0] data;
  logic       byte_ready, sd_cmd, sd_cmd_oe, busy, frame_done, underrun;
  logic [2:0] dbg_state;

  sd_cmd_serializer #(.MAX_BYTES(6), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sd_enable  (sd_enable),
    .sending    (sending),
    .byte_valid (byte_valid),
    .data       (data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .sd_cmd     (sd_cmd),
    .sd_cmd_oe  (sd_cmd_oe),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Capture results of the last run_frame call.
  logic [63:0] cap_bits;
  int          cap_n, fd_cyc, ur_cyc, last_bit_cyc, hold_errs, busy_errs;
  bit          timed_out;

  localparam logic [39:0] CMD0 = 40'h40_00_00_00_00;
  localparam logic [39:0] CMD8 = 40'h48_00_00_01_AA;

  // Feeds nbytes of payload as the tcu would, strobes sd_enable every
  // `period` cycles and records each bit seen on sd_cmd after a strobe.
  // Returns at #1 after the edge that shows frame_done/underrun, or once
  // stop_at bits have been captured (stop_at > 0).
  task automatic run_frame(input logic [39:0] payload, input int nbytes,
                           input bit use_last, input int period, input int stop_at);
    int          idx, cyc;
    bit          acc, stb;
    logic        last_bit;
    logic [39:0] p;
    idx = 0; cyc = 0; cap_bits = '0; cap_n = 0; fd_cyc = -1; ur_cyc = -1;
    last_bit_cyc = -1; hold_errs = 0; busy_errs = 0; timed_out = 0; last_bit = 1'b1;
    sending = 1'b1;
    while (1) begin
      p          = payload << (8 * idx);
      sd_enable  = (cyc % period) == 0;
      byte_valid = idx < nbytes;
      data       = (idx < nbytes) ? p[39:32] : 8'h00;
      byte_last  = use_last && (idx == nbytes - 1);
      acc        = byte_valid && sending && byte_ready;
      stb        = sd_enable;
      @(posedge clk); #1;
      if (acc) idx++;
      if (sd_cmd_oe === 1'b1) begin
        if (stb) begin
          cap_bits     = {cap_bits[62:0], sd_cmd};
          cap_n++;
          last_bit     = sd_cmd;
          last_bit_cyc = cyc;
        end else if (sd_cmd !== last_bit) hold_errs++;
        if (busy !== 1'b1) busy_errs++;
      end
      if (frame_done === 1'b1 && fd_cyc < 0) fd_cyc = cyc;
      if (underrun === 1'b1 && ur_cyc < 0) ur_cyc = cyc;
      cyc++;
      if (fd_cyc >= 0 || ur_cyc >= 0 || (stop_at > 0 && cap_n >= stop_at)) break;
      if (cyc >= 3000) begin timed_out = 1; break; end
    end
    if (stop_at == 0) begin
      sd_enable = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; sd_enable = 1'b0; sending = 1'b0; byte_valid = 1'b0;
    byte_last = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (sd_cmd !== 1'b1) begin tests_failed++; $display("FAIL reset_sd_cmd: got %b expected 1", sd_cmd); end
    tests_run++; if (sd_cmd_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b expected 0", sd_cmd_oe); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (byte_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_byte_ready: got %b expected 1", byte_ready); end
    tests_run++; if ({frame_done, underrun} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 00", {frame_done, underrun}); end
    tests_run++; if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Complete frames: CMD0, CMD8, CMD0 with a slow strobe, CMD0 without byte_last.
  task automatic test_frames();
    logic [39:0] pay  [4];
    logic [7:0]  crcb [4];
    int          per  [4];
    bit          lst  [4];
    logic [47:0] exp_frame;
    pay[0] = CMD0; crcb[0] = 8'h95; per[0] = 1; lst[0] = 1;
    pay[1] = CMD8; crcb[1] = 8'h87; per[1] = 1; lst[1] = 1;
    pay[2] = CMD0; crcb[2] = 8'h95; per[2] = 4; lst[2] = 1;
    pay[3] = CMD0; crcb[3] = 8'h95; per[3] = 1; lst[3] = 0;
    for (int t = 0; t < 4; t++) begin
      run_frame(pay[t], 5, lst[t], per[t], 0);
      exp_frame = {pay[t], crcb[t]};
      tests_run++; if (timed_out || fd_cyc < 0) begin tests_failed++; $display("FAIL frame%0d_done_seen: got fd_cyc=%0d expected a frame_done pulse", t, fd_cyc); end
      tests_run++; if (cap_n != 48) begin tests_failed++; $display("FAIL frame%0d_bit_count: got %0d expected 48", t, cap_n); end
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (cap_bits[47 - 8*i -: 8] !== exp_frame[47 - 8*i -: 8]) begin
          tests_failed++;
          $display("FAIL frame%0d_byte%0d: got %02h expected %02h", t, i, cap_bits[47 - 8*i -: 8], exp_frame[47 - 8*i -: 8]);
        end
      end
      tests_run++; if (fd_cyc - last_bit_cyc != 1) begin tests_failed++; $display("FAIL frame%0d_done_latency: got %0d expected 1", t, fd_cyc - last_bit_cyc); end
      tests_run++; if (hold_errs != 0) begin tests_failed++; $display("FAIL frame%0d_bit_hold: got %0d changes expected 0", t, hold_errs); end
      tests_run++; if (busy_errs != 0) begin tests_failed++; $display("FAIL frame%0d_busy: got %0d low cycles expected 0", t, busy_errs); end
      tests_run++; if (ur_cyc >= 0) begin tests_failed++; $display("FAIL frame%0d_no_underrun: got underrun at %0d expected none", t, ur_cyc); end
      tests_run++;
      if ({sd_cmd_oe, sd_cmd, busy} !== 3'b010) begin
        tests_failed++; $display("FAIL frame%0d_idle_after: got oe,cmd,busy=%b expected 010", t, {sd_cmd_oe, sd_cmd, busy});
      end
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    run_frame(CMD0, 2, 0, 1, 0);
    tests_run++; if (ur_cyc < 0) begin tests_failed++; $display("FAIL stall_underrun_seen: got none expected a pulse"); end
    tests_run++; if (cap_n != 16) begin tests_failed++; $display("FAIL stall_bit_count: got %0d expected 16", cap_n); end
    tests_run++; if (cap_bits[15:0] !== 16'h4000) begin tests_failed++; $display("FAIL stall_bits: got %04h expected 4000", cap_bits[15:0]); end
    tests_run++; if (ur_cyc - last_bit_cyc != 1) begin tests_failed++; $display("FAIL stall_latency: got %0d expected 1", ur_cyc - last_bit_cyc); end
    tests_run++;
    if ({sd_cmd_oe, sd_cmd, busy, byte_ready} !== 4'b0101) begin
      tests_failed++; $display("FAIL stall_idle: got oe,cmd,busy,rdy=%b expected 0101", {sd_cmd_oe, sd_cmd, busy, byte_ready});
    end
    tests_run++; if (fd_cyc >= 0) begin tests_failed++; $display("FAIL stall_no_done: got frame_done at %0d expected none", fd_cyc); end
    @(posedge clk); #1;
    tests_run++; if (underrun !== 1'b0) begin tests_failed++; $display("FAIL stall_pulse_width: got %b expected 0", underrun); end
    run_frame(CMD0, 5, 1, 1, 0);
    tests_run++;
    if (cap_n != 48 || cap_bits[47:0] !== {CMD0, 8'h95}) begin
      tests_failed++; $display("FAIL stall_recover: got %0d bits %012h expected 48 bits %012h", cap_n, cap_bits[47:0], {CMD0, 8'h95});
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int fd_count;
    run_frame(CMD8, 5, 1, 1, 20);
    n_rst = 1'b0;
    #1;
    tests_run++; if (sd_cmd_oe !== 1'b0) begin tests_failed++; $display("FAIL rstmid_oe: got %b expected 0", sd_cmd_oe); end
    tests_run++; if (sd_cmd !== 1'b1) begin tests_failed++; $display("FAIL rstmid_sd_cmd: got %b expected 1", sd_cmd); end
    tests_run++; if (byte_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_byte_ready: got %b expected 1", byte_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    sd_enable = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    fd_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (frame_done === 1'b1) fd_count++;
      if (i == 2) n_rst = 1'b1;
    end
    tests_run++; if (fd_count != 0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", fd_count); end
    run_frame(CMD8, 5, 1, 1, 0);
    tests_run++;
    if (cap_n != 48 || cap_bits[47:0] !== {CMD8, 8'h87}) begin
      tests_failed++; $display("FAIL rstmid_recover: got %0d bits %012h expected 48 bits %012h", cap_n, cap_bits[47:0], {CMD8, 8'h87});
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
